// File: rtl/byte_serializer_8to1.sv
// Parallel-to-serial byte converter: loads a byte over valid/ready and emits it one bit
// per accepted beat, with an optional trailing even-parity beat and a live 3-bit select code.
module byte_serializer_8to1 #(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] x7_x0,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       z0,
  output logic       z0_valid,
  input  logic       z0_ready,
  output logic [2:0] b2_b0,
  output logic       last
);

  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;

  state_t     state;
  logic [7:0] byte_reg;
  logic       parity_reg;
  logic [2:0] next_idx;

  always_comb begin
    next_idx = MSB_FIRST ? (b2_b0 - 3'd1) : (b2_b0 + 3'd1);
  end

  // All outputs are registered, so each branch loads the values for the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      byte_reg   <= '0;
      parity_reg <= 1'b0;
      b2_b0      <= START_IDX;
      z0         <= 1'b0;
      z0_valid   <= 1'b0;
      last       <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_ready <= 1'b1;
          if (load_valid && load_ready) begin
            byte_reg   <= x7_x0;
            parity_reg <= ^x7_x0;
            b2_b0      <= START_IDX;
            z0         <= x7_x0[START_IDX];
            z0_valid   <= 1'b1;
            last       <= 1'b0;
            load_ready <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (z0_ready) begin
            if (b2_b0 != END_IDX) begin
              b2_b0 <= next_idx;
              z0    <= byte_reg[next_idx];
              last  <= (next_idx == END_IDX) && !PARITY_EN;
            end else if (PARITY_EN) begin
              b2_b0 <= START_IDX;
              z0    <= parity_reg;
              last  <= 1'b1;
              state <= PAR;
            end else begin
              b2_b0      <= START_IDX;
              z0         <= 1'b0;
              z0_valid   <= 1'b0;
              last       <= 1'b0;
              load_ready <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        PAR: begin
          if (z0_ready) begin
            z0         <= 1'b0;
            z0_valid   <= 1'b0;
            last       <= 1'b0;
            load_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          b2_b0      <= START_IDX;
          z0         <= 1'b0;
          z0_valid   <= 1'b0;
          last       <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serializer_8to1.sv
// Directed bench for byte_serializer_8to1: three instances cover LSB-first, MSB-first
// and parity-enabled framing; expected beat patterns are written out by hand.
module tb_byte_serializer_8to1;

  logic       clock;
  logic       reset;
  logic [7:0] x   [3];
  logic       lv  [3];
  logic       lr  [3];
  logic       z   [3];
  logic       zv  [3];
  logic       zr  [3];
  logic [2:0] sel [3];
  logic       lst [3];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  byte_serializer_8to1 #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .x7_x0(x[0]), .load_valid(lv[0]), .load_ready(lr[0]),
    .z0(z[0]), .z0_valid(zv[0]), .z0_ready(zr[0]), .b2_b0(sel[0]), .last(lst[0]));

  byte_serializer_8to1 #(.MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_msb (
    .clock(clock), .reset(reset), .x7_x0(x[1]), .load_valid(lv[1]), .load_ready(lr[1]),
    .z0(z[1]), .z0_valid(zv[1]), .z0_ready(zr[1]), .b2_b0(sel[1]), .last(lst[1]));

  byte_serializer_8to1 #(.MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_par (
    .clock(clock), .reset(reset), .x7_x0(x[2]), .load_valid(lv[2]), .load_ready(lr[2]),
    .z0(z[2]), .z0_valid(zv[2]), .z0_ready(zr[2]), .b2_b0(sel[2]), .last(lst[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ends at the negedge after the load edge, where the first beat is visible.
  task automatic load(input int d, input logic [7:0] data, input string tag);
    @(negedge clock);
    check({tag, ".load_ready"}, 32'(lr[d]), 32'd1);
    x[d]  = data;
    lv[d] = 1'b1;
    @(negedge clock);
    lv[d] = 1'b0;
  endtask

  // exp_beats bit k is the value expected on z0 for beat k.
  task automatic expect_frame(input int d, input logic [8:0] exp_beats,
                              input logic [31:0] rdy_pat, input string tag);
    int n;
    int k;
    int c;
    int exp_sel;
    n = (d == 2) ? 9 : 8;
    k = 0;
    c = 0;
    while (k < n && c < 64) begin
      exp_sel = (k >= 8) ? 0 : ((d == 1) ? 7 - k : k);
      check($sformatf("%s.valid%0d", tag, k), 32'(zv[d]), 32'd1);
      check($sformatf("%s.z%0d", tag, k), 32'(z[d]), 32'(exp_beats[k]));
      check($sformatf("%s.sel%0d", tag, k), 32'(sel[d]), 32'(exp_sel));
      check($sformatf("%s.last%0d", tag, k), 32'(lst[d]), (k == n - 1) ? 32'd1 : 32'd0);
      check($sformatf("%s.lready%0d", tag, k), 32'(lr[d]), 32'd0);
      zr[d] = rdy_pat[c % 32];
      if (zv[d] && zr[d]) k++;
      c++;
      @(negedge clock);
    end
    zr[d] = 1'b0;
    check({tag, ".beats"}, 32'(k), 32'(n));
    check({tag, ".idle_valid"}, 32'(zv[d]), 32'd0);
    check({tag, ".idle_z"}, 32'(z[d]), 32'd0);
    check({tag, ".idle_last"}, 32'(lst[d]), 32'd0);
    check({tag, ".idle_ready"}, 32'(lr[d]), 32'd1);
    check({tag, ".idle_sel"}, 32'(sel[d]), (d == 1) ? 32'd7 : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      x[i] = '0; lv[i] = 1'b0; zr[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.valid%0d", i), 32'(zv[i]), 32'd0);
      check($sformatf("rst.ready%0d", i), 32'(lr[i]), 32'd0);
      check($sformatf("rst.z%0d", i), 32'(z[i]), 32'd0);
      check($sformatf("rst.last%0d", i), 32'(lst[i]), 32'd0);
      check($sformatf("rst.sel%0d", i), 32'(sel[i]), (i == 1) ? 32'd7 : 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++)
      check($sformatf("post_rst.ready%0d", i), 32'(lr[i]), 32'd1);

    load(0, 8'hA5, "a5");
    expect_frame(0, 9'h0A5, 32'hFFFF_FFFF, "a5");

    load(1, 8'h81, "msb81");
    expect_frame(1, 9'h081, 32'hFFFF_FFFF, "msb81");

    load(2, 8'h07, "par07");
    expect_frame(2, 9'b1_0000_0111, 32'hFFFF_FFFF, "par07");
    load(2, 8'h03, "par03");
    expect_frame(2, 9'b0_0000_0011, 32'hFFFF_FFFF, "par03");

    load(0, 8'h3C, "stall3c");
    expect_frame(0, 9'h03C, 32'hAAAA_AA29, "stall3c");

    // load_valid held high with the byte swapped to 00 right after FF is captured
    @(negedge clock);
    x[0]  = 8'hFF;
    lv[0] = 1'b1;
    @(negedge clock);
    x[0] = 8'h00;
    expect_frame(0, 9'h0FF, 32'hFFFF_FFFF, "holdff");
    @(negedge clock);
    lv[0] = 1'b0;
    expect_frame(0, 9'h000, 32'hFFFF_FFFF, "hold00");

    // reset on beat 4 of 5A, with a competing load request that must be dropped
    load(0, 8'h5A, "rst5a");
    zr[0] = 1'b1;
    repeat (3) @(negedge clock);
    check("rst5a.sel3", 32'(sel[0]), 32'd3);
    check("rst5a.z3", 32'(z[0]), 32'd1);
    reset = 1'b1;
    x[0]  = 8'hFF;
    lv[0] = 1'b1;
    @(negedge clock);
    zr[0] = 1'b0;
    reset = 1'b0;
    lv[0] = 1'b0;
    check("midrst.valid", 32'(zv[0]), 32'd0);
    check("midrst.sel", 32'(sel[0]), 32'd0);
    check("midrst.ready", 32'(lr[0]), 32'd0);
    check("midrst.z", 32'(z[0]), 32'd0);
    @(negedge clock);
    check("midrst.valid_after", 32'(zv[0]), 32'd0);
    check("midrst.ready_after", 32'(lr[0]), 32'd1);
    load(0, 8'hC3, "c3");
    expect_frame(0, 9'h0C3, 32'hFFFF_FFFF, "c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_serializer_8to1.md
Name: byte_serializer_8to1

Overview:
- Upstream companion of the decoded 8-to-1 multiplexer stage.
- Accepts a parallel byte over a valid/ready handshake, holds it in a register, and walks a 3-bit select counter through all 8 positions.
- Emits the byte one bit per accepted beat on a serial valid/ready output, with an optional trailing even-parity bit.
- Exposes the live select code so the downstream decoded mux (or a bench) can be driven in lock-step.

Parameters:
- MSB_FIRST, 0, 0 = send bit 0 first (select counts 0→7); 1 = send bit 7 first (select counts 7→0).
- PARITY_EN, 0, 1 = append one even-parity bit after the 8 data bits.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- x7_x0  input  8  parallel byte to serialize.
- load_valid  input  1  x7_x0 is valid.
- load_ready  output  1  block can accept a byte.
- z0  output  1  current serial bit.
- z0_valid  output  1  z0 carries a valid bit.
- z0_ready  input  1  consumer takes z0 this cycle.
- b2_b0  output  3  current select code, i.e. index of the bit on z0.
- last  output  1  z0 is the final beat of the frame (bit 7/bit 0, or parity if PARITY_EN).

Behaviour:
- States:
  - IDLE: load_ready=1, z0_valid=0.
  - SEND: z0_valid=1.
  - PAR: only when PARITY_EN=1; z0_valid=1.
- Reset (reset=1 at an edge): state=IDLE, byte register=0, b2_b0=0 (7 if MSB_FIRST), z0=0, z0_valid=0, last=0.
  - load_ready is 0 while reset is high and 1 from the first cycle after reset deasserts.
- Load: in IDLE, load_valid & load_ready at an edge:
  - capture x7_x0;
  - b2_b0 ← start index (0, or 7 if MSB_FIRST);
  - parity register ← XOR of x7_x0;
  - state ← SEND.
  - load_valid outside IDLE is ignored; load_ready=0 in SEND and PAR.
- Output values: z0 = byte_reg[b2_b0] in SEND and parity_reg in PAR, forced 0 in IDLE.
  - All outputs are functions of registered state only; there is no combinational path from z0_ready or load_valid to any output.
- SEND transfer: z0_valid & z0_ready at an edge advances the beat.
  - If b2_b0 ≠ end index (7, or 0 if MSB_FIRST): b2_b0 ← b2_b0 ± 1.
  - Else: state ← PAR if PARITY_EN, else IDLE; b2_b0 ← start index.
- PAR: on z0_ready, state ← IDLE.
- last = 1 in SEND when b2_b0 = end index and PARITY_EN=0, or in PAR; otherwise 0.
- Backpressure: with z0_ready=0, z0, b2_b0, last and z0_valid hold stable indefinitely. The counter never advances without a transfer.
- Latency and throughput:
  - First bit appears on z0 in the cycle after the load edge.
  - With z0_ready held at 1, a frame occupies 8 cycles (9 with parity), plus 1 IDLE cycle before the next load can be accepted.
  - Maximum rate is therefore 1 byte per 9 cycles (10 with parity).
- Wrap-around: the counter wraps only via the reload to the start index at end of frame. Modular wrap 7→0 is never used to sequence bits.
- Reset mid-frame: frame abandoned, all state returns to reset values at that edge, and no further bits of that frame are emitted.
- Simultaneous reset and load_valid: reset wins and the byte is not captured.
- b2_b0 is valid for driving the downstream decoded mux in every state; in IDLE it holds the start index.

Test Plan:
- Reset then load 8'hA5 (MSB_FIRST=0, PARITY_EN=0), z0_ready=1 → z0 over 8 cycles = 1,0,1,0,0,1,0,1; b2_b0 = 0..7; last=1 only on the 8th beat; load_ready returns to 1 the following cycle.
- MSB_FIRST=1, load 8'h81 → z0 = 1,0,0,0,0,0,0,1; b2_b0 = 7..0; last=1 with b2_b0=0.
- PARITY_EN=1, load 8'h07 → 8 data beats then a 9th beat z0=1 (parity of three ones); last=1 only on the 9th beat; 8'h03 instead → 9th beat z0=0.
- Load 8'h3C and toggle z0_ready 1,0,0,1,0,1,… → every bit is delivered exactly once in order; z0 and b2_b0 stay stable during stalls; total transferred beats = 8.
- Assert load_valid continuously with byte changes mid-frame (8'hFF then 8'h00) → second byte is accepted only in IDLE after the first frame; no bit of 8'h00 leaks into the first frame.
- Assert reset during beat 4 of 8'h5A → next cycle z0_valid=0, b2_b0=0, load_ready=0; after release, a fresh load of 8'hC3 serializes correctly from bit 0.
